mgmt_irq_capture: RTL and testbench

//  Interrupt front end feeding the management core IRQ input (the mgmt_gpio irq pad plus user IRQ lines).

---
 rtl/mgmt_irq_capture_pkg.sv | 27 ++
 rtl/mgmt_irq_capture_if.sv | 39 +++
 rtl/mgmt_irq_capture_irq_sync.sv | 36 +++
 rtl/mgmt_irq_capture.sv | 135 +++++++++++++
 tb/tb_mgmt_irq_capture.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mgmt_irq_capture_pkg.sv
// ---------------------------------------------------------------------------
// mgmt_irq_capture_pkg
// Shared constants for the management interrupt capture block:
//   - CSR word indices (decoded from wb_adr_i[4:2])
//   - CSR register width
//   - helper that decides whether a write's byte selects are sufficient
// ---------------------------------------------------------------------------
package mgmt_irq_capture_pkg;

    localparam int IRQ_REG_W = 32;

    localparam logic [2:0] IRQ_RAW  = 3'd0;  // RO  synchronised sources after polarity
    localparam logic [2:0] IRQ_PEND = 3'd1;  // W1C pending bits
    localparam logic [2:0] IRQ_EN   = 3'd2;  // RW  enable mask for irq_o
    localparam logic [2:0] IRQ_MODE = 3'd3;  // RW  1 = edge, 0 = level
    localparam logic [2:0] IRQ_POL  = 3'd4;  // RW  1 = active-low / falling edge

    // Narrow configurations keep every field in byte lane 0, so only sel[0]
    // matters there; wider ones need the full word to avoid partial updates.
    function automatic logic wr_sel_ok(input logic [3:0] sel, input int num_irq);
        if (num_irq <= 8) begin
            return sel[0];
        end
        return (sel == 4'hF);
    endfunction

endpackage

// File: rtl/mgmt_irq_capture_if.sv
// ---------------------------------------------------------------------------
// mgmt_irq_capture_if
// Wishbone-classic CSR bus between the management core and the interrupt
// capture block.
//   wb_cyc_i / wb_stb_i : request qualifiers (master -> slave)
//   wb_we_i             : 1 = write
//   wb_adr_i            : byte address, slave decodes [4:2]
//   wb_dat_i / wb_sel_i : write data and byte selects
//   wb_dat_o            : read data (slave -> master), zero unless ack is high
//   wb_ack_o            : one-cycle acknowledge
//
// Handshake: the master holds cyc, stb, we, adr, dat and sel stable until it
// sees ack. The slave raises ack for exactly one cycle, one cycle after it
// first sees cyc & stb, and never on two consecutive cycles. A write commits
// on the clock edge that raises ack; read data is registered on that same
// edge. The master drops stb (or starts a new request) after the ack cycle.
// ---------------------------------------------------------------------------
interface mgmt_irq_capture_if;

    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o
    );

endinterface

// File: rtl/mgmt_irq_capture_irq_sync.sv
// ---------------------------------------------------------------------------
// irq_sync
// Vector-wide multi-flop synchroniser for asynchronous interrupt sources.
//   clk_i  : destination clock
//   rst_i  : synchronous active-high reset, clears every stage
//   d_i    : asynchronous input vector
//   q_o    : synchronised output, DEPTH clock edges behind d_i
// ---------------------------------------------------------------------------
module irq_sync #(
    parameter int W     = 3,
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sync_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/mgmt_irq_capture.sv
// ---------------------------------------------------------------------------
// mgmt_irq_capture
// Interrupt front end for the management core. Synchronises NUM_IRQ raw
// sources, applies per-source polarity and edge/level detection, keeps
// per-source pending bits and drives one masked, registered request.
//   sys_clk  : single clock, all state on the rising edge
//   sys_rst  : synchronous active-high reset
//   irq_in   : asynchronous raw interrupt sources
//   wb       : Wishbone-classic CSR slave (RAW, PEND, EN, MODE, POL)
//   irq_o    : registered |(pending & enable)
// ---------------------------------------------------------------------------
module mgmt_irq_capture
    import mgmt_irq_capture_pkg::*;
#(
    parameter int NUM_IRQ    = 3,
    parameter int SYNC_DEPTH = 2
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_IRQ-1:0]  irq_in,
    mgmt_irq_capture_if.slave   wb,
    output logic                irq_o
);

    // ------------------------------------------------------------------
    // Source conditioning
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] sync_w;
    logic [NUM_IRQ-1:0] act;
    logic [NUM_IRQ-1:0] act_q;

    irq_sync #(
        .W     (NUM_IRQ),
        .DEPTH (SYNC_DEPTH)
    ) u_irq_sync (
        .clk_i (sys_clk),
        .rst_i (sys_rst),
        .d_i   (irq_in),
        .q_o   (sync_w)
    );

    logic [NUM_IRQ-1:0] pol_q;
    logic [NUM_IRQ-1:0] mode_q;
    logic [NUM_IRQ-1:0] en_q;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] pend_d;

    // Polarity is applied after the synchroniser, so flipping POL can itself
    // produce an edge on act; that is deliberate and may set pending.
    assign act = sync_w ^ pol_q;

    // ------------------------------------------------------------------
    // Wishbone decode
    // ------------------------------------------------------------------
    logic                 ack_q;
    logic [IRQ_REG_W-1:0] dat_q;
    logic                 req;
    logic                 wr;
    logic [2:0]           idx;
    logic [NUM_IRQ-1:0]   wdat;
    logic [IRQ_REG_W-1:0] rd_mux;

    // ~ack_q keeps a held strobe from acknowledging on back-to-back cycles.
    assign req  = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    assign wr   = req & wb.wb_we_i & wr_sel_ok(wb.wb_sel_i, NUM_IRQ);
    assign idx  = wb.wb_adr_i[4:2];
    assign wdat = wb.wb_dat_i[NUM_IRQ-1:0];

    always_comb begin
        rd_mux = '0;
        case (idx)
            IRQ_RAW:  rd_mux[NUM_IRQ-1:0] = act;
            IRQ_PEND: rd_mux[NUM_IRQ-1:0] = pend_q;
            IRQ_EN:   rd_mux[NUM_IRQ-1:0] = en_q;
            IRQ_MODE: rd_mux[NUM_IRQ-1:0] = mode_q;
            IRQ_POL:  rd_mux[NUM_IRQ-1:0] = pol_q;
            default:  rd_mux = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Pending logic
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] set_vec;
    logic [NUM_IRQ-1:0] w1c_vec;

    assign set_vec = (mode_q & act & ~act_q) | (~mode_q & act);
    assign w1c_vec = (wr && idx == IRQ_PEND) ? wdat : '0;

    // Set is OR-ed in after the clear so a simultaneous set wins; in level
    // mode this also makes W1C ineffective while the source is active.
    assign pend_d = (pend_q & ~w1c_vec) | set_vec;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic irq_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            act_q  <= '0;
            pend_q <= '0;
            en_q   <= '0;
            mode_q <= '0;
            pol_q  <= '0;
            ack_q  <= 1'b0;
            dat_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            act_q  <= act;
            pend_q <= pend_d;
            irq_q  <= |(pend_q & en_q);
            ack_q  <= req;
            // Zero outside the ack cycle so the bus never sees stale data.
            dat_q  <= (req && !wb.wb_we_i) ? rd_mux : '0;
            if (wr) begin
                case (idx)
                    IRQ_EN:   en_q   <= wdat;
                    IRQ_MODE: mode_q <= wdat;
                    IRQ_POL:  pol_q  <= wdat;
                    default:  ;
                endcase
            end
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign irq_o       = irq_q;

    // Address bits outside [4:2] and data bits above NUM_IRQ are don't-care.
    logic unused_ok;
    assign unused_ok = ^{wb.wb_adr_i[31:5], wb.wb_adr_i[1:0], wb.wb_dat_i, wb.wb_sel_i};

endmodule

// File: tb/tb_mgmt_irq_capture.sv
module tb_mgmt_irq_capture;
    import mgmt_irq_capture_pkg::*;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [2:0] irq_in;
    logic       irq_o;

    int tests_run    = 0;
    int tests_failed = 0;

    mgmt_irq_capture_if wb_if ();

    mgmt_irq_capture #(
        .NUM_IRQ    (3),
        .SYNC_DEPTH (2)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .irq_in  (irq_in),
        .wb      (wb_if.slave),
        .irq_o   (irq_o)
    );

    // ---------------- clock ----------------
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic wb_idle();
        wb_if.wb_cyc_i = 1'b0;
        wb_if.wb_stb_i = 1'b0;
        wb_if.wb_we_i  = 1'b0;
        wb_if.wb_adr_i = '0;
        wb_if.wb_dat_i = '0;
        wb_if.wb_sel_i = '0;
    endtask

    task automatic wb_write(input logic [2:0] idx, input logic [31:0] data, input logic [3:0] sel);
        if (wb_if.wb_ack_o) step(1);
        wb_if.wb_cyc_i = 1'b1;
        wb_if.wb_stb_i = 1'b1;
        wb_if.wb_we_i  = 1'b1;
        wb_if.wb_adr_i = {27'd0, idx, 2'b00};
        wb_if.wb_dat_i = data;
        wb_if.wb_sel_i = sel;
        step(1);
        tests_run++;
        if (wb_if.wb_ack_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL wr_ack idx=%0d got=%b exp=1", idx, wb_if.wb_ack_o);
        end
        wb_idle();
    endtask

    task automatic wb_read(input logic [2:0] idx, output logic [31:0] data);
        if (wb_if.wb_ack_o) step(1);
        wb_if.wb_cyc_i = 1'b1;
        wb_if.wb_stb_i = 1'b1;
        wb_if.wb_we_i  = 1'b0;
        wb_if.wb_adr_i = {27'd0, idx, 2'b00};
        wb_if.wb_sel_i = 4'hF;
        step(1);
        tests_run++;
        if (wb_if.wb_ack_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL rd_ack idx=%0d got=%b exp=1", idx, wb_if.wb_ack_o);
            data = 'x;
        end else begin
            data = wb_if.wb_dat_o;
        end
        wb_idle();
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        logic [31:0] d;
        sys_rst = 1'b1;
        irq_in  = '0;
        wb_idle();
        step(3);
        tests_run++;
        if (irq_o !== 1'b0 || wb_if.wb_ack_o !== 1'b0 || wb_if.wb_dat_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs got irq=%b ack=%b dat=%h exp 0/0/0",
                     irq_o, wb_if.wb_ack_o, wb_if.wb_dat_o);
        end
        sys_rst = 1'b0;
        step(1);
        for (int i = 0; i < 8; i++) begin
            wb_read(i[2:0], d);
            tests_run++;
            if (d !== 32'd0) begin
                tests_failed++;
                $display("FAIL reset_csr idx=%0d got=%h exp=0", i, d);
            end
        end
        wb_write(IRQ_EN, 32'h7, 4'h1);
        wb_read(IRQ_EN, d);
        tests_run++;
        if (d !== 32'h7) begin
            tests_failed++;
            $display("FAIL en_rw got=%h exp=7", d);
        end
        wb_read(3'd6, d);
        tests_run++;
        if (d !== 32'd0) begin
            tests_failed++;
            $display("FAIL idx6_zero got=%h exp=0", d);
        end
        wb_write(3'd7, 32'hFFFF_FFFF, 4'hF);
        wb_read(3'd7, d);
        tests_run++;
        if (d !== 32'd0) begin
            tests_failed++;
            $display("FAIL idx7_zero got=%h exp=0", d);
        end
        wb_write(IRQ_EN, 32'hFFFF_FFFF, 4'hF);
        wb_read(IRQ_EN, d);
        tests_run++;
        if (d !== 32'h7) begin
            tests_failed++;
            $display("FAIL en_upper_bits got=%h exp=7", d);
        end
    endtask

    task automatic test_bus_rules();
        logic [31:0] d;
        // sel[0] low: write ignored, EN keeps 7
        wb_write(IRQ_EN, 32'h0, 4'hE);
        wb_read(IRQ_EN, d);
        tests_run++;
        if (d !== 32'h7) begin
            tests_failed++;
            $display("FAIL sel0_ignored got=%h exp=7", d);
        end
        // held strobe: ack 1,0,1 with data zero in the gap
        step(1);
        wb_if.wb_cyc_i = 1'b1;
        wb_if.wb_stb_i = 1'b1;
        wb_if.wb_we_i  = 1'b0;
        wb_if.wb_adr_i = {27'd0, IRQ_EN, 2'b00};
        step(1);
        tests_run++;
        if (wb_if.wb_ack_o !== 1'b1 || wb_if.wb_dat_o !== 32'h7) begin
            tests_failed++;
            $display("FAIL held_ack1 got ack=%b dat=%h exp 1/7", wb_if.wb_ack_o, wb_if.wb_dat_o);
        end
        step(1);
        tests_run++;
        if (wb_if.wb_ack_o !== 1'b0 || wb_if.wb_dat_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL held_gap got ack=%b dat=%h exp 0/0", wb_if.wb_ack_o, wb_if.wb_dat_o);
        end
        step(1);
        tests_run++;
        if (wb_if.wb_ack_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL held_ack2 got=%b exp=1", wb_if.wb_ack_o);
        end
        wb_idle();
        wb_write(IRQ_EN, 32'h0, 4'h1);
    endtask

    task automatic test_edge_irq();
        logic [31:0] d;
        wb_write(IRQ_MODE, 32'h1, 4'h1);
        wb_write(IRQ_POL,  32'h0, 4'h1);
        wb_write(IRQ_EN,   32'h1, 4'h1);
        irq_in[0] = 1'b1;       // stable before edge 1
        step(3);                // after edge 3: pending just set, irq_o not yet
        tests_run++;
        if (irq_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL edge_irq_e3 got=%b exp=0", irq_o);
        end
        wb_read(IRQ_PEND, d);   // ack on edge 4, returns pending after edge 3
        tests_run++;
        if (d !== 32'h1) begin
            tests_failed++;
            $display("FAIL edge_pend got=%h exp=1", d);
        end
        tests_run++;
        if (irq_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL edge_irq_e4 got=%b exp=1", irq_o);
        end
        wb_write(IRQ_PEND, 32'h1, 4'h1);
        tests_run++;
        if (irq_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL w1c_irq_ack_edge got=%b exp=1", irq_o);
        end
        step(1);
        tests_run++;
        if (irq_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL w1c_irq_fall got=%b exp=0", irq_o);
        end
        wb_read(IRQ_PEND, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL edge_no_reset got=%h exp=0", d);
        end
        irq_in[0] = 1'b0;
        step(3);
    endtask

    task automatic test_level();
        logic [31:0] d;
        wb_write(IRQ_MODE, 32'h0, 4'h1);
        wb_write(IRQ_EN,   32'h2, 4'h1);
        irq_in[1] = 1'b1;
        step(4);
        wb_write(IRQ_PEND, 32'h2, 4'h1);
        wb_read(IRQ_PEND, d);
        tests_run++;
        if (d !== 32'h2) begin
            tests_failed++;
            $display("FAIL level_hold got=%h exp=2", d);
        end
        tests_run++;
        if (irq_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL level_irq got=%b exp=1", irq_o);
        end
        irq_in[1] = 1'b0;
        step(4);
        wb_write(IRQ_PEND, 32'h2, 4'h1);
        wb_read(IRQ_PEND, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL level_clear got=%h exp=0", d);
        end
        step(1);
        tests_run++;
        if (irq_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL level_irq_off got=%b exp=0", irq_o);
        end
    endtask

    task automatic test_masked();
        logic [31:0] d;
        wb_write(IRQ_EN,   32'h0, 4'h1);
        wb_write(IRQ_MODE, 32'h4, 4'h1);
        irq_in[2] = 1'b1;
        step(4);
        wb_read(IRQ_PEND, d);
        tests_run++;
        if (d !== 32'h4) begin
            tests_failed++;
            $display("FAIL masked_pend got=%h exp=4", d);
        end
        tests_run++;
        if (irq_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL masked_irq got=%b exp=0", irq_o);
        end
        wb_write(IRQ_EN, 32'h4, 4'h1);
        tests_run++;
        if (irq_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL unmask_ack_edge got=%b exp=0", irq_o);
        end
        step(1);
        tests_run++;
        if (irq_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL unmask_irq got=%b exp=1", irq_o);
        end
        wb_write(IRQ_EN, 32'h0, 4'h1);
        wb_write(IRQ_PEND, 32'h4, 4'h1);
        irq_in[2] = 1'b0;
        step(4);
        wb_read(IRQ_PEND, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL masked_cleanup got=%h exp=0", d);
        end
    endtask

    task automatic test_set_vs_clear();
        logic [31:0] d;
        step(1);                // ack low, idle bus
        irq_in[2] = 1'b1;       // stable before edge k
        step(2);                // after edge k+1
        wb_write(IRQ_PEND, 32'h4, 4'h1);  // ack edge k+2 == set edge
        wb_read(IRQ_PEND, d);
        tests_run++;
        if (d !== 32'h4) begin
            tests_failed++;
            $display("FAIL set_wins got=%h exp=4", d);
        end
        wb_write(IRQ_PEND, 32'h4, 4'h1);
        wb_read(IRQ_PEND, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL later_w1c got=%h exp=0", d);
        end
    endtask

    task automatic test_polarity();
        logic [31:0] d;
        wb_write(IRQ_MODE, 32'h5, 4'h1);
        wb_write(IRQ_POL,  32'h1, 4'h1);   // act[0] 0->1: creates an edge
        step(2);
        wb_read(IRQ_PEND, d);
        tests_run++;
        if (d !== 32'h1) begin
            tests_failed++;
            $display("FAIL pol_change_edge got=%h exp=1", d);
        end
        irq_in[0] = 1'b1;
        step(4);
        wb_write(IRQ_PEND, 32'h1, 4'h1);
        wb_read(IRQ_RAW, d);
        tests_run++;
        if (d !== 32'h4) begin
            tests_failed++;
            $display("FAIL raw_pol_high got=%h exp=4", d);
        end
        wb_read(IRQ_PEND, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL pol_rise_ignored got=%h exp=0", d);
        end
        irq_in[0] = 1'b0;
        step(4);
        wb_read(IRQ_PEND, d);
        tests_run++;
        if (d !== 32'h1) begin
            tests_failed++;
            $display("FAIL pol_fall_pend got=%h exp=1", d);
        end
        wb_read(IRQ_RAW, d);
        tests_run++;
        if (d !== 32'h5) begin
            tests_failed++;
            $display("FAIL raw_pol_low got=%h exp=5", d);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d;
        irq_in = '0;
        step(1);
        wb_if.wb_cyc_i = 1'b1;
        wb_if.wb_stb_i = 1'b1;
        wb_if.wb_we_i  = 1'b1;
        wb_if.wb_adr_i = {27'd0, IRQ_EN, 2'b00};
        wb_if.wb_dat_i = 32'h7;
        wb_if.wb_sel_i = 4'hF;
        sys_rst = 1'b1;
        step(1);
        tests_run++;
        if (wb_if.wb_ack_o !== 1'b0 || irq_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_ack got ack=%b irq=%b exp 0/0", wb_if.wb_ack_o, irq_o);
        end
        wb_idle();
        step(1);
        sys_rst = 1'b0;
        step(1);
        wb_read(IRQ_EN, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_en got=%h exp=0", d);
        end
        wb_read(IRQ_POL, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_pol got=%h exp=0", d);
        end
        wb_read(IRQ_PEND, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_pend got=%h exp=0", d);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_bus_rules();
        test_edge_irq();
        test_level();
        test_masked();
        test_set_vs_clear();
        test_polarity();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
